// File: rtl/mov_avg_pkg.sv
// Shared widths and the round/shift helper for the moving-average filters.
package mov_avg_pkg;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int sel_width(input int max_shift);
        return (max_shift > 0) ? $clog2(max_shift + 1) : 1;
    endfunction

    function automatic int acc_width(input int w, input int max_shift);
        return w + max_shift;
    endfunction

    // acc must arrive extended to 64 bits; sgn picks arithmetic shift.
    function automatic logic [63:0] round_shift(
        input logic [63:0] acc,
        input logic [5:0]  k,
        input logic        sgn,
        input logic        rnd
    );
        logic [63:0] t;
        t = acc;
        if (rnd && k != 6'd0)
            t = acc + (64'd1 << (k - 6'd1));
        if (sgn)
            return $signed(t) >>> k;
        return t >> k;
    endfunction

endpackage

// File: rtl/mov_avg_mc_line.sv
// Per-channel circular delay lines with running sums and fill counters.
module mov_avg_mc_line #(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 4,
    parameter int MAX_SHIFT = 4,
    parameter int CH_W      = 2,
    parameter int SEL_W     = 3,
    parameter int ACC_W     = 20
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clr,
    input  logic [SEL_W-1:0]   k,
    input  logic [CH_W-1:0]    ch,
    input  logic               we,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [ACC_W-1:0]   wr_acc,
    input  logic [MAX_SHIFT:0] wr_fcnt,
    output logic [WIDTH-1:0]   rd_old,
    output logic [ACC_W-1:0]   rd_acc,
    output logic [MAX_SHIFT:0] rd_fcnt
);

    localparam int DEPTH = 1 << MAX_SHIFT;
    localparam logic [MAX_SHIFT-1:0] ONE = 1;

    logic [WIDTH-1:0]     mem  [CHANNELS][DEPTH];
    logic [ACC_W-1:0]     acc  [CHANNELS];
    logic [MAX_SHIFT-1:0] wptr [CHANNELS];
    logic [MAX_SHIFT:0]   fcnt [CHANNELS];
    logic [MAX_SHIFT-1:0] ridx;

    // A full-depth window shifts ONE out to 0, so it reads at wptr itself.
    always_comb begin
        ridx    = wptr[ch] - (ONE << k);
        rd_old  = mem[ch][ridx];
        rd_acc  = acc[ch];
        rd_fcnt = fcnt[ch];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c]  <= '0;
                wptr[c] <= '0;
                fcnt[c] <= '0;
                for (int i = 0; i < DEPTH; i++)
                    mem[c][i] <= '0;
            end
        end else if (clr) begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c]  <= '0;
                wptr[c] <= '0;
                fcnt[c] <= '0;
                for (int i = 0; i < DEPTH; i++)
                    mem[c][i] <= '0;
            end
        end else if (we) begin
            mem[ch][wptr[ch]] <= wr_data;
            acc[ch]           <= wr_acc;
            fcnt[ch]          <= wr_fcnt;
            wptr[ch]          <= wptr[ch] + ONE;
        end
    end

endmodule

// File: rtl/mov_avg_mc.sv
// Multi-channel time-multiplexed boxcar averager, window 2^k.
// Stage 1 reads/updates the bank, stage 2 rounds and shifts.
module mov_avg_mc
    import mov_avg_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 4,
    parameter int MAX_SHIFT = 4,
    parameter int DEF_SHIFT = 2,
    parameter int SIGNED    = 0,
    parameter int ROUND     = 1,
    localparam int CH_W     = ch_width(CHANNELS),
    localparam int SEL_W    = sel_width(MAX_SHIFT)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] idata,
    input  logic [CH_W-1:0]  ichan,
    input  logic             ivalid,
    input  logic [SEL_W-1:0] win_sel,
    input  logic             flush,
    output logic [WIDTH-1:0] odata,
    output logic [CH_W-1:0]  ochan,
    output logic             ovalid,
    output logic             ofill
);

    localparam int ACC_W = acc_width(WIDTH, MAX_SHIFT);
    localparam int CNT_W = MAX_SHIFT + 1;
    localparam logic [CH_W:0]    CH_LIM = (CH_W + 1)'(CHANNELS);
    localparam logic [CNT_W-1:0] ONE    = 1;
    localparam logic [SEL_W-1:0] K_MAX  = SEL_W'(MAX_SHIFT);
    localparam logic [SEL_W-1:0] K_DEF  = SEL_W'(DEF_SHIFT);

    logic [SEL_W-1:0] k_q;

    logic             s1_v;
    logic [CH_W-1:0]  s1_ch;
    logic [WIDTH-1:0] s1_d;

    logic             s2_v;
    logic             s2_fill;
    logic [CH_W-1:0]  s2_ch;
    logic [ACC_W-1:0] s2_acc;

    logic [WIDTH-1:0] rd_old;
    logic [ACC_W-1:0] rd_acc;
    logic [CNT_W-1:0] rd_fcnt;

    logic [ACC_W-1:0] d_ext;
    logic [ACC_W-1:0] old_ext;
    logic [ACC_W-1:0] acc_new;
    logic [CNT_W-1:0] wlen;
    logic [CNT_W-1:0] fcnt_new;
    logic [63:0]      acc64;
    logic             bank_we;
    logic             d_sx;
    logic             o_sx;
    logic             a_sx;

    // The bank is written on the edge that loads stage 2, so a
    // same-channel sample right behind already reads the new sum.
    mov_avg_mc_line #(
        .WIDTH     (WIDTH),
        .CHANNELS  (CHANNELS),
        .MAX_SHIFT (MAX_SHIFT),
        .CH_W      (CH_W),
        .SEL_W     (SEL_W),
        .ACC_W     (ACC_W)
    ) u_line (
        .clock   (clock),
        .reset   (reset),
        .clr     (flush),
        .k       (k_q),
        .ch      (s1_ch),
        .we      (bank_we),
        .wr_data (s1_d),
        .wr_acc  (acc_new),
        .wr_fcnt (fcnt_new),
        .rd_old  (rd_old),
        .rd_acc  (rd_acc),
        .rd_fcnt (rd_fcnt)
    );

    always_comb begin
        d_sx     = (SIGNED != 0) & s1_d[WIDTH-1];
        o_sx     = (SIGNED != 0) & rd_old[WIDTH-1];
        a_sx     = (SIGNED != 0) & s2_acc[ACC_W-1];
        d_ext    = {{MAX_SHIFT{d_sx}}, s1_d};
        old_ext  = {{MAX_SHIFT{o_sx}}, rd_old};
        acc_new  = rd_acc - old_ext + d_ext;
        wlen     = ONE << k_q;
        fcnt_new = (rd_fcnt == wlen) ? rd_fcnt : rd_fcnt + ONE;
        acc64    = {{(64 - ACC_W){a_sx}}, s2_acc};
        bank_we  = s1_v & ~flush;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            k_q     <= K_DEF;
            s1_v    <= 1'b0;
            s1_ch   <= '0;
            s1_d    <= '0;
            s2_v    <= 1'b0;
            s2_ch   <= '0;
            s2_acc  <= '0;
            s2_fill <= 1'b0;
            odata   <= '0;
            ochan   <= '0;
            ovalid  <= 1'b0;
            ofill   <= 1'b0;
        end else if (flush) begin
            k_q    <= (win_sel > K_MAX) ? K_MAX : win_sel;
            s1_v   <= 1'b0;
            s2_v   <= 1'b0;
            ovalid <= 1'b0;
        end else begin
            s1_v    <= ivalid && ({1'b0, ichan} < CH_LIM);
            s1_ch   <= ichan;
            s1_d    <= idata;
            s2_v    <= s1_v;
            s2_ch   <= s1_ch;
            s2_acc  <= acc_new;
            s2_fill <= (fcnt_new == wlen);
            ovalid  <= s2_v;
            if (s2_v) begin
                odata <= WIDTH'(round_shift(acc64, 6'(k_q),
                                            SIGNED != 0,
                                            ROUND != 0));
                ochan <= s2_ch;
                ofill <= s2_fill;
            end
        end
    end

endmodule

// File: doc/mov_avg_mc.md
Name: mov_avg_mc

Overview:
Multi-channel, time-multiplexed boxcar moving-average filter for the Comm/Filter library. It is the parametrised successor to the single-channel power-of-two averager. Samples from up to CHANNELS interleaved streams arrive tagged with a channel index. Each channel keeps its own delay line and running sum. The window length (2^k) is selected at run time, signedness and rounding mode are parameters, and a fill flag marks when an output covers a full window.

Parameters:
WIDTH, 16, sample and output width in bits
CHANNELS, 4, number of independent channels (>=1)
MAX_SHIFT, 4, log2 of the largest window; delay-line depth per channel = 2^MAX_SHIFT
DEF_SHIFT, 2, window shift loaded at reset (<= MAX_SHIFT)
SIGNED, 0, 1 = two's-complement samples and arithmetic shift; 0 = unsigned
ROUND, 1, 1 = round half up (add 2^(k-1) before shift); 0 = truncate

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
idata  in  WIDTH  input sample
ichan  in  CH_W  channel tag of idata; CH_W = max(1, clog2(CHANNELS))
ivalid  in  1  idata/ichan valid this cycle
win_sel  in  SEL_W  requested window shift k; SEL_W = clog2(MAX_SHIFT+1)
flush  in  1  synchronous clear of all channel state; also loads win_sel
odata  out  WIDTH  averaged output
ochan  out  CH_W  channel tag of odata
ovalid  out  1  odata/ochan/ofill valid, single-cycle pulse
ofill  out  1  window for ochan fully populated at this output

Behaviour:
- Reset (reset=0, asynchronous):
  - all delay lines, accumulators, per-channel write pointers and fill counters cleared to 0
  - active shift register k_q = DEF_SHIFT
  - odata=0, ochan=0, ovalid=0, ofill=0
- Accumulator width is WIDTH+MAX_SHIFT, sign-extended when SIGNED=1. It never overflows.
- Per-sample update, window W = 2^k_q:
  - acc_new = acc - oldest + idata, where oldest = delay[ch][(wptr-W) mod 2^MAX_SHIFT]
  - oldest reads as 0 until W samples have been written since the last clear, because cleared lines hold 0
  - then write idata at wptr, wptr++ (wraps at 2^MAX_SHIFT), fill count saturates at W
- Output:
  - odata = (acc_new + (ROUND ? 2^(k_q-1) : 0)) >> k_q, using an arithmetic shift if SIGNED, truncated to WIDTH
  - when k_q=0 there is no rounding term and odata = idata
  - ofill=1 iff this sample's fill count reached W
  - outputs before fill are partial sums divided by W; they are still emitted, with ofill=0
- Latency and throughput:
  - ivalid at rising edge N gives ovalid at edge N+2
  - full throughput of one sample per clock, in any channel order
  - back-to-back samples on the same channel must be correct; stage-2 results are forwarded into stage 1 for both the accumulator and the oldest-sample read
- ichan >= CHANNELS: sample ignored, no ovalid, no state change.
- flush=1:
  - next edge clears all channel state
  - k_q = min(win_sel, MAX_SHIFT)
  - in-flight pipeline stages invalidated, so no ovalid at N+1 or N+2 for earlier samples
  - an ivalid in the same cycle is dropped
  - flush has priority over ivalid
- win_sel is ignored except on flush. A window change therefore always restarts from empty.
- ovalid is a pulse with no backpressure. The downstream block must accept every output.

Decomposition:
- Package mov_avg_pkg holds:
  - clog2-based width constants CH_W, SEL_W, ACC_W
  - the rounding/shift function shared with future filters
- One sub-module is natural: mov_avg_mc_line, a per-channel circular delay line plus accumulator register bank.
  - It is a register array with a read port at (wptr-W) and a write port.
  - It is instantiated once with a CHANNELS x 2^MAX_SHIFT memory.
  - The top level keeps the 2-stage pipeline, forwarding, flush and output logic.

Test Plan:
1. Fill and steady state. Settings: WIDTH=16, DEF_SHIFT=2, ROUND=1, ch0. Inputs 1,2,3,4,5 on spaced cycles produce odata 0,1,2,3,4 with ofill 0,0,0,1,1. Repeating with ROUND=0 produces 0,0,1,2,3.
2. Same-channel back-to-back. Window 4, ch0, consecutive cycles 4,8,12,16,20 produce odata 1,3,6,10,14, each at exactly N+2.
3. Interleaved channels. Window 2, with ch0=8 and ch1=100 alternating every cycle for 4 samples. ch0 produces 4,8 and ch1 produces 50,100; ochan tags match and ofill=1 on each channel's second output.
4. Signed mode. SIGNED=1, window 2, ch2 inputs -3,-4,-4 produce odata -1,-3,-4.
5. Flush and window change. Mid-stream, with 2 samples in flight, pulse flush with win_sel=3 plus a coincident ivalid. The in-flight samples produce no ovalid and the coincident sample is dropped. Then 8 samples of 16 produce odata 2,4,...,16 and ofill rises on the 8th. A further flush with win_sel=7 clamps to MAX_SHIFT=4.
6. Async reset mid-operation. Drop reset between edges during streaming. Outputs go to 0 immediately, without waiting for a clock edge. After release, the first ch0 input of 4 yields odata 1 (DEF_SHIFT window). An ichan=CHANNELS input yields no ovalid.
